// File: rtl/cmos_config_sequencer.sv
// cmos_config_sequencer
// Brings up an OV7670 after power-on. It pulses the camera hardware reset,
// waits for the sensor to settle, then walks a register table and hands each
// entry to the SCCB byte-writer. A NACKed write is retried up to MAX_RETRY
// extra times. The done output gates the downstream BRAM controller.
//
// Ports
//   sysclk, sysrst     : clock; asynchronous active-low reset
//   start              : one-cycle pulse; (re)runs configuration when not busy
//   rom_addr/rom_data  : synchronous table ROM, data valid one cycle after address
//                        entry = {reg[15:8], val[7:0]}; FFFF = end, FFF0 = delay
//   sccb_req/reg/val   : write request; transfer occurs on sccb_req && sccb_ready
//   sccb_ready         : writer idle and accepting
//   sccb_done/nack     : completion pulse; nack is valid with done
//   cmos_rst_n         : camera hardware reset, active-low
//   busy/done/error    : run status
//   writes_ok          : acknowledged writes in the current run
module cmos_config_sequencer #(
  parameter int ROM_AW        = 8,
  parameter int RESET_CYCLES  = 100000,
  parameter int SETTLE_CYCLES = 300000,
  parameter int DELAY_CYCLES  = 1000000,
  parameter int MAX_RETRY     = 3
) (
  input  logic              sysclk,
  input  logic              sysrst,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sccb_req,
  output logic [7:0]        sccb_reg,
  output logic [7:0]        sccb_val,
  input  logic              sccb_ready,
  input  logic              sccb_done,
  input  logic              sccb_nack,
  output logic              cmos_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ROM_AW:0]   writes_ok
);

  typedef enum logic [3:0] {
    S_IDLE, S_HW_RESET, S_SETTLE, S_FETCH, S_DECODE, S_DELAY,
    S_ISSUE, S_WAIT_DONE, S_ADVANCE, S_DONE, S_ERROR
  } state_t;

  localparam int RW = $clog2(MAX_RETRY + 1) + 1;
  localparam logic [31:0]   RST_LAST  = 32'(RESET_CYCLES - 1);
  localparam logic [31:0]   SET_LAST  = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0]   DLY_LAST  = 32'(DELAY_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  state_t            r_state;
  logic [31:0]       r_cnt;
  logic [RW-1:0]     r_retry;
  logic [ROM_AW-1:0] r_rom_addr;
  logic              r_sccb_req;
  logic [7:0]        r_sccb_reg;
  logic [7:0]        r_sccb_val;
  logic              r_cmos_rst_n;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic [ROM_AW:0]   r_writes_ok;

  logic w_accept;
  logic w_last_slot;

  assign w_accept    = r_sccb_req && sccb_ready;
  // The table never wraps: once the top slot is consumed the run is over.
  assign w_last_slot = (r_rom_addr == '1);

  always_ff @(posedge sysclk or negedge sysrst) begin
    if (!sysrst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_retry      <= '0;
      r_rom_addr   <= '0;
      r_sccb_req   <= 1'b0;
      r_sccb_reg   <= '0;
      r_sccb_val   <= '0;
      r_cmos_rst_n <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_writes_ok  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          r_cmos_rst_n <= 1'b1;
          r_sccb_req   <= 1'b0;
          if (start) begin
            r_state      <= S_HW_RESET;
            r_cmos_rst_n <= 1'b0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_writes_ok  <= '0;
            r_retry      <= '0;
            r_cnt        <= '0;
          end
        end
        S_HW_RESET: begin
          if (r_cnt == RST_LAST) begin
            r_state      <= S_SETTLE;
            r_cmos_rst_n <= 1'b1;
            r_cnt        <= '0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_SETTLE: begin
          if (r_cnt == SET_LAST) begin
            r_state    <= S_FETCH;
            r_rom_addr <= '0;
            r_cnt      <= '0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        // Address is presented here; the ROM registers it at the end of the cycle.
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          if (rom_data == 16'hFFFF) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (rom_data == 16'hFFF0) begin
            r_state <= S_DELAY;
            r_cnt   <= '0;
          end else begin
            r_sccb_reg <= rom_data[15:8];
            r_sccb_val <= rom_data[7:0];
            r_sccb_req <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        S_DELAY: begin
          if (r_cnt == DLY_LAST) begin
            r_state <= S_ADVANCE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_ISSUE: begin
          if (w_accept) begin
            r_sccb_req <= 1'b0;
            r_state    <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (sccb_done) begin
            if (!sccb_nack) begin
              r_writes_ok <= r_writes_ok + 1'b1;
              r_retry     <= '0;
              r_state     <= S_ADVANCE;
            end else if (r_retry < RETRY_MAX) begin
              // Re-issue the same entry; reg/val are still latched.
              r_retry    <= r_retry + 1'b1;
              r_sccb_req <= 1'b1;
              r_state    <= S_ISSUE;
            end else begin
              r_state <= S_ERROR;
              r_busy  <= 1'b0;
              r_error <= 1'b1;
            end
          end
        end
        S_ADVANCE: begin
          if (w_last_slot) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_rom_addr <= r_rom_addr + 1'b1;
            r_state    <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rom_addr   = r_rom_addr;
  assign sccb_req   = r_sccb_req;
  assign sccb_reg   = r_sccb_reg;
  assign sccb_val   = r_sccb_val;
  assign cmos_rst_n = r_cmos_rst_n;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign writes_ok  = r_writes_ok;

endmodule

// File: tb/tb_cmos_config_sequencer.sv
module tb_cmos_config_sequencer;
  localparam int AW = 4, RC = 4, SC = 8, DC = 16, MR = 2;

  logic sysclk = 1'b0, sysrst = 1'b0, start = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [15:0] rom_data;
  logic sccb_req, sccb_ready, sccb_done, sccb_nack;
  logic [7:0] sccb_reg, sccb_val;
  logic cmos_rst_n, busy, done, error;
  logic [AW:0] writes_ok;

  logic [15:0] rom [16];
  int n_vec = 0, n_err = 0;

  always #5 sysclk = ~sysclk;

  cmos_config_sequencer #(.ROM_AW(AW), .RESET_CYCLES(RC), .SETTLE_CYCLES(SC),
                          .DELAY_CYCLES(DC), .MAX_RETRY(MR)) dut (
    .sysclk(sysclk), .sysrst(sysrst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .sccb_req(sccb_req), .sccb_reg(sccb_reg), .sccb_val(sccb_val), .sccb_ready(sccb_ready),
    .sccb_done(sccb_done), .sccb_nack(sccb_nack), .cmos_rst_n(cmos_rst_n), .busy(busy),
    .done(done), .error(error), .writes_ok(writes_ok));

  // Synchronous table ROM
  always @(posedge sysclk) rom_data <= rom[rom_addr];

  // SCCB writer model: ready 2 cycles after req, done 5 cycles after acceptance,
  // the first nack_plan completions of a run are NACKs.
  int req_age = 0, done_cnt = 0, nack_cnt = 0, nack_plan = 0;
  always @(posedge sysclk or negedge sysrst) begin
    if (!sysrst) begin
      sccb_ready <= 1'b0; sccb_done <= 1'b0; sccb_nack <= 1'b0;
      req_age <= 0; done_cnt <= 0;
    end else begin
      sccb_done <= 1'b0; sccb_nack <= 1'b0;
      if (start) nack_cnt <= 0;
      if (sccb_req && sccb_ready) begin
        sccb_ready <= 1'b0; req_age <= 0; done_cnt <= 5;
      end else if (sccb_req && done_cnt == 0) begin
        req_age <= req_age + 1;
        if (req_age + 1 >= 2) sccb_ready <= 1'b1;
      end
      if (done_cnt > 0) begin
        done_cnt <= done_cnt - 1;
        if (done_cnt == 1) begin
          sccb_done <= 1'b1;
          sccb_nack <= (nack_cnt < nack_plan);
          nack_cnt  <= nack_cnt + 1;
        end
      end
    end
  end

  // Observation logs, sampled on the falling edge
  logic [15:0] obs_q[$];
  int done_t[$], req_t[$];
  int cyc = 0, stab_bad = 0, rst_falls = 0, wraps = 0;
  logic p_req = 1'b0, p_rst = 1'b1;
  logic [15:0] p_rv = '0;
  logic [AW-1:0] p_addr = '0;
  always @(posedge sysclk) cyc <= cyc + 1;
  always @(negedge sysclk) begin
    if (sccb_req && sccb_ready) obs_q.push_back({sccb_reg, sccb_val});
    if (sccb_done) done_t.push_back(cyc);
    if (sccb_req && !p_req) req_t.push_back(cyc);
    if (sccb_req && p_req && {sccb_reg, sccb_val} != p_rv) stab_bad++;
    if (!cmos_rst_n && p_rst) rst_falls++;
    if (rom_addr == '0 && p_addr != '0) wraps++;
    p_req = sccb_req; p_rv = {sccb_reg, sccb_val}; p_rst = cmos_rst_n; p_addr = rom_addr;
  end

  // Reference model: walks the table by its rules, consuming NACKs in order.
  logic [15:0] exp_q[$];
  int exp_ok, exp_addr;
  bit exp_err;
  task automatic model_run(input int nacks);
    exp_q.delete(); exp_ok = 0; exp_err = 0; exp_addr = 15;
    for (int a = 0; a < 16; a++) begin
      if (rom[a] == 16'hFFFF) begin exp_addr = a; break; end
      if (rom[a] == 16'hFFF0) continue;
      for (int t = 0; t <= MR; t++) begin
        exp_q.push_back(rom[a]);
        if (nacks > 0) begin nacks--; if (t == MR) exp_err = 1; end
        else begin exp_ok++; break; end
      end
      if (exp_err) begin exp_addr = a; break; end
    end
  endtask

  function automatic int qdiff();
    if (obs_q.size() != exp_q.size()) return -2;
    foreach (obs_q[i]) if (obs_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic clr_logs();
    obs_q.delete(); done_t.delete(); req_t.delete();
    stab_bad = 0; rst_falls = 0; wraps = 0;
  endtask

  task automatic pulse_start();
    @(negedge sysclk) start = 1'b1;
    @(negedge sysclk) start = 1'b0;
  endtask

  task automatic wait_end(output bit to);
    int n = 0;
    while (!(done || error) && n < 3000) begin @(negedge sysclk); n++; end
    to = (n >= 3000);
  endtask

  task automatic run(input int nacks, output bit to);
    clr_logs(); nack_plan = nacks; model_run(nacks);
    pulse_start();
    wait_end(to);
  endtask

  task automatic load(input logic [15:0] a, b, c, d);
    for (int i = 0; i < 16; i++) rom[i] = 16'hFFFF;
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
  endtask

  task automatic test_reset();
    int lo = 0, n = 0, gap;
    bit bad = 0;
    sysrst = 1'b0; start = 1'b0;
    repeat (3) @(negedge sysclk);
    n_vec++; if ({rom_addr, sccb_req, sccb_reg, sccb_val, cmos_rst_n, busy, done, error, writes_ok} !== '0) begin
      n_err++; $display("FAIL reset_vals got %h want 0", {rom_addr, sccb_req, sccb_reg, sccb_val, cmos_rst_n, busy, done, error, writes_ok}); end
    sysrst = 1'b1;
    load(16'h1280, 16'h1204, 16'h0C00, 16'hFFFF);
    @(negedge sysclk);
    n_vec++; if (cmos_rst_n !== 1'b1) begin n_err++; $display("FAIL idle_rst_n got %b want 1", cmos_rst_n); end
    clr_logs(); nack_plan = 0;
    pulse_start();
    while (!cmos_rst_n && lo < 100) begin
      lo++; if (busy !== 1'b1 || done !== 1'b0) bad = 1;
      @(negedge sysclk);
    end
    n_vec++; if (lo != RC) begin n_err++; $display("FAIL hw_reset_len got %0d want %0d", lo, RC); end
    gap = cyc;
    while (!sccb_req && n < 100) begin
      n++; if (busy !== 1'b1 || done !== 1'b0) bad = 1;
      @(negedge sysclk);
    end
    gap = cyc - gap;
    n_vec++; if (!sccb_req || gap < SC) begin n_err++; $display("FAIL settle_gap got %0d req=%b want >=%0d", gap, sccb_req, SC); end
    n_vec++; if (bad) begin n_err++; $display("FAIL busy_during_bringup got bad=1 want busy=1 done=0"); end
    wait_end(bad);
  endtask

  task automatic test_table();
    bit to;
    load(16'h1280, 16'h1204, 16'h0C00, 16'hFFFF);
    run(0, to);
    n_vec++; if (to) begin n_err++; $display("FAIL t2_timeout got timeout want done"); end
    n_vec++; if (qdiff() != -1) begin n_err++; $display("FAIL t2_writes got %0d writes want %0d (diff %0d)", obs_q.size(), exp_q.size(), qdiff()); end
    n_vec++; if ({done, busy, error} !== 3'b100) begin n_err++; $display("FAIL t2_flags got %b want 100", {done, busy, error}); end
    n_vec++; if (writes_ok !== 5'd3) begin n_err++; $display("FAIL t2_writes_ok got %0d want 3", writes_ok); end
    n_vec++; if (rom_addr !== 4'd3) begin n_err++; $display("FAIL t2_rom_addr got %0d want 3", rom_addr); end
    n_vec++; if (stab_bad != 0) begin n_err++; $display("FAIL t2_req_stable got %0d changes want 0", stab_bad); end
  endtask

  task automatic test_delay();
    bit to;
    int gap;
    load(16'h1280, 16'hFFF0, 16'h1100, 16'hFFFF);
    run(0, to);
    gap = (req_t.size() >= 2 && done_t.size() >= 1) ? req_t[1] - done_t[0] : -1;
    n_vec++; if (to || gap < DC) begin n_err++; $display("FAIL t3_delay_gap got %0d want >=%0d", gap, DC); end
    n_vec++; if (writes_ok !== 5'(exp_ok)) begin n_err++; $display("FAIL t3_writes_ok got %0d want %0d", writes_ok, exp_ok); end
    n_vec++; if (qdiff() != -1) begin n_err++; $display("FAIL t3_writes got %0d writes want %0d", obs_q.size(), exp_q.size()); end
  endtask

  task automatic test_retry();
    bit to;
    load(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    run(2, to);
    n_vec++; if (to || obs_q.size() != 3 || done_t.size() != 3) begin n_err++; $display("FAIL t4_retry_cycles got %0d req %0d done want 3", obs_q.size(), done_t.size()); end
    n_vec++; if ({done, error} !== 2'b10) begin n_err++; $display("FAIL t4_retry_ok got done,error=%b want 10", {done, error}); end
    n_vec++; if (writes_ok !== 5'd1) begin n_err++; $display("FAIL t4_retry_wok got %0d want 1", writes_ok); end
    run(3, to);
    n_vec++; if (to || {done, error, busy} !== 3'b010) begin n_err++; $display("FAIL t4_error_flags got %b want 010", {done, error, busy}); end
    n_vec++; if (writes_ok !== 5'd0 || exp_err != 1) begin n_err++; $display("FAIL t4_error_wok got %0d want 0", writes_ok); end
    repeat (40) @(negedge sysclk);
    n_vec++; if (obs_q.size() != 3 || req_t.size() != 3 || sccb_req !== 1'b0) begin n_err++; $display("FAIL t4_no_more_req got %0d reqs want 3", req_t.size()); end
  endtask

  task automatic test_full_and_restart();
    bit to;
    int n = 0, lo = 0;
    for (int i = 0; i < 16; i++) rom[i] = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 255))};
    clr_logs(); nack_plan = 0; model_run(0);
    pulse_start();
    while (obs_q.size() == 0 && n < 200) begin @(negedge sysclk); n++; end
    wraps = 0;
    pulse_start();  // busy: must be ignored
    wait_end(to);
    n_vec++; if (to || qdiff() != -1) begin n_err++; $display("FAIL t5_writes got %0d want 16 (to=%0b)", obs_q.size(), to); end
    n_vec++; if (writes_ok !== 5'd16 || rom_addr !== 4'd15) begin n_err++; $display("FAIL t5_end got wok=%0d addr=%0d want 16/15", writes_ok, rom_addr); end
    n_vec++; if (wraps != 0 || rst_falls != 1) begin n_err++; $display("FAIL t5_nowrap got wraps=%0d rst_falls=%0d want 0/1", wraps, rst_falls); end
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL t5_done got %b want 1", done); end
    clr_logs(); model_run(0);
    pulse_start();
    while (!cmos_rst_n && lo < 100) begin lo++; @(negedge sysclk); end
    n_vec++; if (lo != RC) begin n_err++; $display("FAIL t5_rerun_rst_len got %0d want %0d", lo, RC); end
    wait_end(to);
    n_vec++; if (to || qdiff() != -1 || writes_ok !== 5'd16) begin n_err++; $display("FAIL t5_rerun got %0d writes wok=%0d want 16", obs_q.size(), writes_ok); end
  endtask

  task automatic test_async_reset();
    bit to;
    int n = 0;
    load(16'h1280, 16'h1204, 16'hFFFF, 16'hFFFF);
    clr_logs(); nack_plan = 0;
    pulse_start();
    while (!sccb_req && n < 200) begin @(negedge sysclk); n++; end
    n_vec++; if (sccb_req !== 1'b1) begin n_err++; $display("FAIL t6_reach_req got %b want 1", sccb_req); end
    sysrst = 1'b0; #1;
    n_vec++; if ({rom_addr, sccb_req, sccb_reg, sccb_val, cmos_rst_n, busy, done, error, writes_ok} !== '0) begin
      n_err++; $display("FAIL t6_rst_in_issue got %h want 0", {rom_addr, sccb_req, sccb_reg, sccb_val, cmos_rst_n, busy, done, error, writes_ok}); end
    @(negedge sysclk) sysrst = 1'b1;
    clr_logs(); n = 0;
    pulse_start();
    while (!sccb_req && n < 200) begin @(negedge sysclk); n++; end
    n_vec++; if (rom_addr !== 4'd0 || {sccb_reg, sccb_val} !== 16'h1280) begin n_err++; $display("FAIL t6_restart got addr=%0d rv=%h want 0/1280", rom_addr, {sccb_reg, sccb_val}); end
    n = 0;
    while (!(obs_q.size() > 0 && !sccb_req) && n < 200) begin @(negedge sysclk); n++; end
    @(negedge sysclk);
    sysrst = 1'b0; #1;
    n_vec++; if ({rom_addr, sccb_req, sccb_reg, sccb_val, cmos_rst_n, busy, done, error, writes_ok} !== '0 || done_t.size() != 0) begin
      n_err++; $display("FAIL t6_rst_in_wait got %h dones=%0d want 0/0", {rom_addr, sccb_req, sccb_reg, sccb_val, cmos_rst_n, busy, done, error, writes_ok}, done_t.size()); end
    @(negedge sysclk) sysrst = 1'b1;
    run(0, to);
    n_vec++; if (to || qdiff() != -1 || writes_ok !== 5'd2) begin n_err++; $display("FAIL t6_rerun got %0d writes wok=%0d want 2", obs_q.size(), writes_ok); end
  endtask

  task automatic test_random();
    bit to;
    int r, nk;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 16; i++) begin
        r = $urandom_range(0, 9);
        if (r == 0) rom[i] = 16'hFFF0;
        else if (r == 1 && i >= 2) rom[i] = 16'hFFFF;
        else rom[i] = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 255))};
      end
      nk = $urandom_range(0, 3);
      run(nk, to);
      n_vec++; if (to || qdiff() != -1) begin n_err++; $display("FAIL rnd%0d_writes got %0d want %0d nacks=%0d", it, obs_q.size(), exp_q.size(), nk); end
      n_vec++; if (writes_ok !== 5'(exp_ok) || rom_addr !== 4'(exp_addr)) begin
        n_err++; $display("FAIL rnd%0d_end got wok=%0d addr=%0d want %0d/%0d", it, writes_ok, rom_addr, exp_ok, exp_addr); end
      n_vec++; if ({done, error, busy} !== {!exp_err, exp_err, 1'b0}) begin
        n_err++; $display("FAIL rnd%0d_flags got %b want %b", it, {done, error, busy}, {!exp_err, exp_err, 1'b0}); end
    end
  endtask

  initial begin
    test_reset();
    test_table();
    test_delay();
    test_retry();
    test_full_and_restart();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
